// File: rtl/multicycle_seq_ctrl.sv
// rtl/multicycle_seq_ctrl.sv - multi-cycle instruction sequencer with MEM wait/timeout and counters
// Optional single-step PAUSE state: define SEQ_SINGLE_STEP_EN.
module multicycle_seq_ctrl #(
    parameter int                  OPCODE_W    = 6,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = OPCODE_W'(6'b100100),
    parameter int                  MEM_TIMEOUT = 15,
    parameter int                  CNT_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                updPc,
    input  logic                wr_reg,
    input  logic                rdMem,
    input  logic                wrMem,
    input  logic                stall,
    input  logic                mem_ready,
    input  logic                step,
    output logic                ir_load,
    output logic                upd_pc_en,
    output logic                wr_reg_en,
    output logic                rd_mem_en,
    output logic                wr_mem_en,
    output logic [2:0]          state,
    output logic                halted,
    output logic                error,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [CNT_W-1:0]    retired_count
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITE_OUT = 3'd4,
        S_HALT      = 3'd5,
        S_ERROR     = 3'd6,
        S_PAUSE     = 3'd7
    } state_t;

    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t             state_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [CNT_W-1:0]   cycle_q;
    logic [CNT_W-1:0]   retired_q;
    logic               count_en;
    logic               timeout_hit;

`ifndef SEQ_SINGLE_STEP_EN
    logic unused_step;
    assign unused_step = step;
`endif

    assign count_en    = (state_q != S_HALT) && (state_q != S_ERROR) && (state_q != S_PAUSE);
    // This not-ready cycle is the MEM_TIMEOUT-th consecutive one.
    assign timeout_hit = (MEM_TIMEOUT != 0) && ((32'(wait_q) + 32'd1) == 32'(MEM_TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            if (count_en && (cycle_q != {CNT_W{1'b1}})) begin
                cycle_q <= cycle_q + 1'b1;
            end
            case (state_q)
                S_FETCH: begin
                    if (!stall) state_q <= S_DECODE;
                end
                S_DECODE: state_q <= S_EXECUTE;
                S_EXECUTE: begin
                    wait_q <= '0;
                    if (opcode == HALT_OPCODE)  state_q <= S_HALT;
                    else if (rdMem || wrMem)    state_q <= S_MEM;
                    else                        state_q <= S_WRITE_OUT;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state_q <= S_WRITE_OUT;
                        wait_q  <= '0;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                        if (timeout_hit) state_q <= S_ERROR;
                    end
                end
                S_WRITE_OUT: begin
                    if (retired_q != {CNT_W{1'b1}}) retired_q <= retired_q + 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
                    state_q <= S_PAUSE;
`else
                    state_q <= S_FETCH;
`endif
                end
                S_HALT:  state_q <= S_HALT;
                S_ERROR: state_q <= S_ERROR;
                default: begin
`ifdef SEQ_SINGLE_STEP_EN
                    if (step) state_q <= S_FETCH;
`else
                    state_q <= S_FETCH;
`endif
                end
            endcase
        end
    end

    // Raw strobes reach the datapath only in their owning state, never during reset.
    always_comb begin
        ir_load   = 1'b0;
        upd_pc_en = 1'b0;
        wr_reg_en = 1'b0;
        rd_mem_en = 1'b0;
        wr_mem_en = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: ir_load = !stall;
                S_MEM: begin
                    rd_mem_en = rdMem;
                    wr_mem_en = wrMem;
                end
                S_WRITE_OUT: begin
                    upd_pc_en = updPc;
                    wr_reg_en = wr_reg;
                end
                default: ;
            endcase
        end
    end

    assign state         = state_q;
    assign halted        = (state_q == S_HALT);
    assign error         = (state_q == S_ERROR);
    assign cycle_count   = cycle_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// tb/tb_multicycle_seq_ctrl.sv - scoreboard bench for multicycle_seq_ctrl (default build, MEM_TIMEOUT=4)
module tb_multicycle_seq_ctrl;

    localparam logic [5:0] OP_ALU = 6'h01;
    localparam logic [5:0] OP_LD  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_HLT = 6'h24;

    typedef struct packed {
        logic [2:0]  st;
        logic        ir;
        logic        upd;
        logic        wr;
        logic        rd;
        logic        wm;
        logic        hl;
        logic        er;
        logic [31:0] cyc;
        logic [31:0] ret;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        updPc, wr_reg, rdMem, wrMem, stall, mem_ready, step;
    logic        ir_load, upd_pc_en, wr_reg_en, rd_mem_en, wr_mem_en;
    logic [2:0]  state;
    logic        halted, error;
    logic [31:0] cycle_count, retired_count;

    exp_t        sb_q[$];
    int          checks = 0;
    int          passed = 0;
    int          cyc_no = 0;

    multicycle_seq_ctrl #(
        .OPCODE_W(6), .HALT_OPCODE(6'b100100), .MEM_TIMEOUT(4), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .updPc(updPc), .wr_reg(wr_reg),
        .rdMem(rdMem), .wrMem(wrMem), .stall(stall), .mem_ready(mem_ready), .step(step),
        .ir_load(ir_load), .upd_pc_en(upd_pc_en), .wr_reg_en(wr_reg_en),
        .rd_mem_en(rd_mem_en), .wr_mem_en(wr_mem_en), .state(state),
        .halted(halted), .error(error), .cycle_count(cycle_count), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    // raw = {updPc, wr_reg, rdMem, wrMem}; eo = {ir_load, upd_pc_en, wr_reg_en, rd_mem_en, wr_mem_en}
    task automatic cyc(input logic [5:0] op, input logic [3:0] raw, input logic st, input logic mr,
                       input logic rst, input logic [2:0] es, input logic [4:0] eo,
                       input int ec, input int er);
        exp_t e;
        opcode    = op;
        {updPc, wr_reg, rdMem, wrMem} = raw;
        stall     = st;
        mem_ready = mr;
        reset     = rst;
        e.st  = es;
        {e.ir, e.upd, e.wr, e.rd, e.wm} = eo;
        e.hl  = (es == 3'd5);
        e.er  = (es == 3'd6);
        e.cyc = 32'(ec);
        e.ret = 32'(er);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = sb_q.pop_front();
            a = '{state, ir_load, upd_pc_en, wr_reg_en, rd_mem_en, wr_mem_en,
                  halted, error, cycle_count, retired_count};
            checks++;
            cyc_no++;
            if (a === e) passed++;
            else $display("FAIL cycle%0d: actual st=%0d en=%b%b%b%b%b h=%b e=%b cyc=%0d ret=%0d, required st=%0d en=%b%b%b%b%b h=%b e=%b cyc=%0d ret=%0d",
                          cyc_no, a.st, a.ir, a.upd, a.wr, a.rd, a.wm, a.hl, a.er, a.cyc, a.ret,
                          e.st, e.ir, e.upd, e.wr, e.rd, e.wm, e.hl, e.er, e.cyc, e.ret);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; opcode = OP_ALU; updPc = 0; wr_reg = 0; rdMem = 0; wrMem = 0;
        stall = 0; mem_ready = 0; step = 0;
        @(posedge clk);
        #1;
        cyc(OP_ALU, 4'b0000, 0, 0, 1, 3'd0, 5'b00000, 0, 0);
        // ALU instruction: 0,1,2,4
        cyc(OP_ALU, 4'b1100, 0, 0, 0, 3'd0, 5'b10000, 0, 0);
        cyc(OP_ALU, 4'b1100, 0, 0, 0, 3'd1, 5'b00000, 1, 0);
        cyc(OP_ALU, 4'b1100, 0, 0, 0, 3'd2, 5'b00000, 2, 0);
        cyc(OP_ALU, 4'b1100, 0, 0, 0, 3'd4, 5'b01100, 3, 0);
        // Load, three wait cycles then ready (ready on the would-be timeout cycle)
        cyc(OP_LD, 4'b1110, 0, 0, 0, 3'd0, 5'b10000, 4, 1);
        cyc(OP_LD, 4'b1110, 0, 0, 0, 3'd1, 5'b00000, 5, 1);
        cyc(OP_LD, 4'b1110, 0, 0, 0, 3'd2, 5'b00000, 6, 1);
        cyc(OP_LD, 4'b1110, 0, 0, 0, 3'd3, 5'b00010, 7, 1);
        cyc(OP_LD, 4'b1110, 0, 0, 0, 3'd3, 5'b00010, 8, 1);
        cyc(OP_LD, 4'b1110, 0, 0, 0, 3'd3, 5'b00010, 9, 1);
        cyc(OP_LD, 4'b1110, 0, 1, 0, 3'd3, 5'b00010, 10, 1);
        cyc(OP_LD, 4'b1110, 0, 0, 0, 3'd4, 5'b01100, 11, 1);
        // Three stall cycles in FETCH
        for (int i = 0; i < 3; i++)
            cyc(OP_ALU, 4'b0000, 1, 0, 0, 3'd0, 5'b00000, 12 + i, 2);
        cyc(OP_ALU, 4'b0000, 0, 0, 0, 3'd0, 5'b10000, 15, 2);
        cyc(OP_ALU, 4'b0000, 0, 0, 0, 3'd1, 5'b00000, 16, 2);
        cyc(OP_ALU, 4'b0000, 0, 0, 0, 3'd2, 5'b00000, 17, 2);
        cyc(OP_ALU, 4'b0000, 0, 0, 0, 3'd4, 5'b00000, 18, 2);
        // Zero-wait store
        cyc(OP_SW, 4'b0001, 0, 0, 0, 3'd0, 5'b10000, 19, 3);
        cyc(OP_SW, 4'b0001, 0, 0, 0, 3'd1, 5'b00000, 20, 3);
        cyc(OP_SW, 4'b0001, 0, 0, 0, 3'd2, 5'b00000, 21, 3);
        cyc(OP_SW, 4'b0001, 0, 1, 0, 3'd3, 5'b00001, 22, 3);
        cyc(OP_SW, 4'b0001, 0, 0, 0, 3'd4, 5'b00000, 23, 3);
        // Store timing out after four not-ready cycles
        cyc(OP_SW, 4'b0001, 0, 0, 0, 3'd0, 5'b10000, 24, 4);
        cyc(OP_SW, 4'b0001, 0, 0, 0, 3'd1, 5'b00000, 25, 4);
        cyc(OP_SW, 4'b0001, 0, 0, 0, 3'd2, 5'b00000, 26, 4);
        for (int i = 0; i < 4; i++)
            cyc(OP_SW, 4'b0001, 0, 0, 0, 3'd3, 5'b00001, 27 + i, 4);
        cyc(OP_SW, 4'b0001, 0, 0, 0, 3'd6, 5'b00000, 31, 4);
        cyc(OP_SW, 4'b0001, 0, 1, 0, 3'd6, 5'b00000, 31, 4);
        cyc(OP_SW, 4'b0001, 0, 0, 0, 3'd6, 5'b00000, 31, 4);
        cyc(OP_SW, 4'b0001, 0, 0, 1, 3'd6, 5'b00000, 31, 4);
        // HALT wins over a memory strobe; reset leaves HALT
        cyc(OP_HLT, 4'b1111, 0, 0, 0, 3'd0, 5'b10000, 0, 0);
        cyc(OP_HLT, 4'b1111, 0, 0, 0, 3'd1, 5'b00000, 1, 0);
        cyc(OP_HLT, 4'b1111, 0, 0, 0, 3'd2, 5'b00000, 2, 0);
        cyc(OP_HLT, 4'b1111, 0, 0, 0, 3'd5, 5'b00000, 3, 0);
        cyc(OP_HLT, 4'b1111, 0, 1, 0, 3'd5, 5'b00000, 3, 0);
        cyc(OP_HLT, 4'b1111, 0, 0, 1, 3'd5, 5'b00000, 3, 0);
        // Reset in the middle of a MEM wait
        cyc(OP_LD, 4'b0010, 0, 0, 0, 3'd0, 5'b10000, 0, 0);
        cyc(OP_LD, 4'b0010, 0, 0, 0, 3'd1, 5'b00000, 1, 0);
        cyc(OP_LD, 4'b0010, 0, 0, 0, 3'd2, 5'b00000, 2, 0);
        cyc(OP_LD, 4'b0010, 0, 0, 0, 3'd3, 5'b00010, 3, 0);
        cyc(OP_LD, 4'b0010, 0, 0, 0, 3'd3, 5'b00010, 4, 0);
        cyc(OP_LD, 4'b0010, 0, 0, 1, 3'd3, 5'b00000, 5, 0);
        // Fresh load after reset: wait count restarts from zero
        cyc(OP_LD, 4'b0010, 0, 0, 0, 3'd0, 5'b10000, 0, 0);
        cyc(OP_LD, 4'b0010, 0, 0, 0, 3'd1, 5'b00000, 1, 0);
        cyc(OP_LD, 4'b0010, 0, 0, 0, 3'd2, 5'b00000, 2, 0);
        for (int i = 0; i < 3; i++)
            cyc(OP_LD, 4'b0010, 0, 0, 0, 3'd3, 5'b00010, 3 + i, 0);
        cyc(OP_LD, 4'b0010, 0, 1, 0, 3'd3, 5'b00010, 6, 0);
        cyc(OP_LD, 4'b0010, 0, 0, 0, 3'd4, 5'b00000, 7, 0);
        cyc(OP_ALU, 4'b0000, 0, 0, 0, 3'd0, 5'b10000, 8, 1);

        @(negedge clk);
        checks++;
        if (sb_q.size() == 0) passed++;
        else $display("FAIL drain: actual %0d entries left, required 0", sb_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
